// File: rtl/gnr_ctrl_pkg.sv
// Shared types and helpers for the gene-network attractor sequencer.
// The TRANS state is only reachable when GNR_TRANSIENT_EN is defined.
package gnr_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MEET,
        PERIOD,
        TRANS,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TR_RST,
        TR_LEAD,
        TR_WALK
    } trans_phase_t;

    // True when one more step would take the counter to the limit.
    // Counters are at most 32 bits wide.
    function automatic logic at_limit(input logic [31:0] cnt, input logic [31:0] lim);
        return (lim == 32'd0) || (cnt >= lim - 32'd1);
    endfunction

endpackage

// File: rtl/gnr_vec_cmp.sv
// Tortoise/hare equality with step-count qualifiers (minimum count, even-only).
// Operands are the nodes' own registered outputs, so the hit is usable as a Mealy decision.
module gnr_vec_cmp
    import gnr_ctrl_pkg::*;
#(
    parameter int unsigned N_NODES = 8,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic [N_NODES-1:0] i_a,
    input  logic [N_NODES-1:0] i_b,
    input  logic [CNT_W-1:0]   i_cnt,
    input  logic [CNT_W-1:0]   i_min,
    input  logic               i_need_even,
    output logic               o_eq,
    output logic               o_hit
);

    logic [N_NODES-1:0] w_diff;

    for (genvar gi = 0; gi < N_NODES; gi++) begin : g_bit
        assign w_diff[gi] = i_a[gi] ^ i_b[gi];
    end

    assign o_eq  = ~|w_diff;
    assign o_hit = o_eq && (i_cnt >= i_min) && (!i_need_even || !i_cnt[0]);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer driving a Boolean gene-network node array.
// Define GNR_TRANSIENT_EN to add the transient-length phase and res_transient output.
module gnr_attractor_ctrl
    import gnr_ctrl_pkg::*;
#(
    parameter int unsigned N_NODES   = 8,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned MAX_STEPS = 32'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_in,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_timeout,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
`ifdef GNR_TRANSIENT_EN
    output logic [CNT_W-1:0]   res_transient,
`endif
    output logic [N_NODES-1:0] res_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_ONE + CNT_ONE;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [N_NODES-1:0] r_init, w_init_next;
    logic [N_NODES-1:0] r_res_state, w_res_state_next;
    logic [CNT_W-1:0]   r_meet, w_meet_next;
    logic [CNT_W-1:0]   r_period, w_period_next;
    logic               r_timeout, w_timeout_next;
    logic [CNT_W-1:0]   w_cmp_min;
    logic               w_cmp_even;
    logic               w_eq;
    logic               w_hit;
    logic               w_lim;
`ifdef GNR_TRANSIENT_EN
    trans_phase_t       r_phase, w_phase_next;
    logic [CNT_W-1:0]   r_transient, w_transient_next;
`endif

    gnr_vec_cmp #(
        .N_NODES (N_NODES),
        .CNT_W   (CNT_W)
    ) u_cmp (
        .i_a         (s0_vec),
        .i_b         (s1_vec),
        .i_cnt       (r_cnt),
        .i_min       (w_cmp_min),
        .i_need_even (w_cmp_even),
        .o_eq        (w_eq),
        .o_hit       (w_hit)
    );

    assign w_lim = at_limit(32'(r_cnt), 32'(MAX_STEPS));

    // MEET needs k even and >=2; PERIOD any p>=1; the transient walk checks even counts from 0.
    always_comb begin
        w_cmp_min  = '0;
        w_cmp_even = 1'b1;
        case (r_state)
            MEET:   w_cmp_min = CNT_TWO;
            PERIOD: begin
                w_cmp_min  = CNT_ONE;
                w_cmp_even = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_init_next      = r_init;
        w_res_state_next = r_res_state;
        w_meet_next      = r_meet;
        w_period_next    = r_period;
        w_timeout_next   = r_timeout;
`ifdef GNR_TRANSIENT_EN
        w_phase_next     = r_phase;
        w_transient_next = r_transient;
`endif
        reset_nos        = 1'b0;
        start_s0         = 1'b0;
        start_s1         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_init_next      = init_in;
                    w_res_state_next = '0;
                    w_meet_next      = '0;
                    w_period_next    = '0;
                    w_timeout_next   = 1'b0;
`ifdef GNR_TRANSIENT_EN
                    w_transient_next = '0;
`endif
                    w_state_next     = INIT;
                end
            end
            INIT: begin
                reset_nos    = 1'b1;
                w_cnt_next   = '0;
                w_state_next = MEET;
            end
            MEET: begin
                if (w_hit) begin
                    w_meet_next      = r_cnt >> 1;
                    w_res_state_next = s0_vec;
                    w_cnt_next       = '0;
                    w_state_next     = PERIOD;
                end else begin
                    start_s0 = 1'b1;
                    start_s1 = 1'b1;
                    if (w_lim) begin
                        w_timeout_next = 1'b1;
                        w_state_next   = DONE;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end
            end
            PERIOD: begin
                if (w_hit) begin
                    w_period_next = r_cnt;
                    w_cnt_next    = '0;
`ifdef GNR_TRANSIENT_EN
                    w_phase_next  = TR_RST;
                    w_state_next  = TRANS;
`else
                    w_state_next  = DONE;
`endif
                end else begin
                    start_s1 = 1'b1;
                    if (w_lim) begin
                        w_timeout_next   = 1'b1;
                        w_meet_next      = '0;
                        w_res_state_next = '0;
                        w_state_next     = DONE;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end
            end
`ifdef GNR_TRANSIENT_EN
            // Both copies restart at init; the hare is first led one period ahead,
            // then both walk in lockstep until they coincide at the attractor entry.
            TRANS: begin
                case (r_phase)
                    TR_RST: begin
                        reset_nos    = 1'b1;
                        w_cnt_next   = '0;
                        w_phase_next = TR_LEAD;
                    end
                    TR_LEAD: begin
                        start_s1 = 1'b1;
                        if (r_cnt == r_period - CNT_ONE) begin
                            w_cnt_next   = '0;
                            w_phase_next = TR_WALK;
                        end else begin
                            w_cnt_next = r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        if (w_hit) begin
                            w_transient_next = r_cnt >> 1;
                            w_state_next     = DONE;
                        end else begin
                            start_s0 = 1'b1;
                            start_s1 = ~r_cnt[0];
                            if (w_lim) begin
                                w_timeout_next   = 1'b1;
                                w_meet_next      = '0;
                                w_period_next    = '0;
                                w_res_state_next = '0;
                                w_state_next     = DONE;
                            end else begin
                                w_cnt_next = r_cnt + CNT_ONE;
                            end
                        end
                    end
                endcase
            end
`endif
            DONE: begin
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_init      <= '0;
            r_res_state <= '0;
            r_meet      <= '0;
            r_period    <= '0;
            r_timeout   <= 1'b0;
`ifdef GNR_TRANSIENT_EN
            r_phase     <= TR_RST;
            r_transient <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_init      <= w_init_next;
            r_res_state <= w_res_state_next;
            r_meet      <= w_meet_next;
            r_period    <= w_period_next;
            r_timeout   <= w_timeout_next;
`ifdef GNR_TRANSIENT_EN
            r_phase     <= w_phase_next;
            r_transient <= w_transient_next;
`endif
        end
    end

    assign init_state  = r_init;
    assign busy        = (r_state != IDLE) && (r_state != DONE);
    assign res_valid   = (r_state == DONE);
    assign res_timeout = r_timeout;
    assign res_meet    = r_meet;
    assign res_period  = r_period;
    assign res_state   = r_res_state;
`ifdef GNR_TRANSIENT_EN
    assign res_transient = r_transient;
`endif

endmodule
